weight_stream_ctrl: RTL

//  Native-RTL sequencer for a conv-layer weight ROM; it replaces the HLS weight reader in front of the `rom` instance.
//  It is started by an ap_ctrl_hs handshake. It streams the full kernel (MEM_SIZE coeffs) NUM_PASSES times into an ap_fifo output.
//  It absorbs the 1-cycle ROM read latency and output back-pressure with a 2-entry buffer, so the stream runs at 1 coeff/cycle.

---
 rtl/weight_stream_ctrl_pkg.sv | 10 +
 rtl/weight_skid_buf.sv | 37 +++
 rtl/weight_stream_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/weight_stream_ctrl_pkg.sv
// weight_stream_ctrl_pkg: shared sizes, FSM state encoding and address-width helper
package weight_stream_ctrl_pkg;
  localparam int KERN_S_N = 16;
  localparam int COEFF_WIDTH = 16;
  localparam int NUM_PASSES_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/weight_skid_buf.sv
// weight_skid_buf: 2-entry FIFO with push/pop, occupancy count and head data
module weight_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  // the caller's credit scheme must keep these impossible
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count == 2'd2));
      assert (!(pop && count == 2'd0));
    end
  end
endmodule

// File: rtl/weight_stream_ctrl.sv
// weight_stream_ctrl: streams the weight ROM NUM_PASSES times into an ap_fifo at 1 coeff/cycle
module weight_stream_ctrl
  import weight_stream_ctrl_pkg::*;
#(
  parameter int MEM_SIZE = KERN_S_N,
  parameter int DATA_WIDTH = COEFF_WIDTH,
  parameter int NUM_PASSES = NUM_PASSES_DEF,
  localparam int AW = addr_w(MEM_SIZE),
  localparam int PW = $clog2(NUM_PASSES + 1)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write,
  output logic [AW-1:0]         rom_address,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q
);
  localparam logic [AW-1:0] LAST_A = AW'(MEM_SIZE - 1);
  localparam logic [PW-1:0] LAST_P = PW'(NUM_PASSES - 1);
  state_t state, state_n;
  logic [AW-1:0] addr;
  logic [PW-1:0] pass_cnt;
  logic inflight, issue, pop, last;
  logic [1:0] count;
  logic [2:0] occ;
  assign output_V_write = count != 2'd0;
  assign pop = output_V_write & output_V_full_n;
  // words owed to the buffer: stored plus the read still in the ROM pipeline
  assign occ = {1'b0, count} + {2'b0, inflight};
  assign issue = state == RUN && (occ - {2'b0, pop}) < 3'd2;
  assign last = addr == LAST_A && pass_cnt == LAST_P;
  assign rom_ce = issue;
  assign rom_address = addr;
  assign ap_idle = state == IDLE;
  assign ap_ready = state == IDLE && ap_start;
  assign ap_done = state == DRAIN && pop && count == 2'd1 && !inflight;
  always_comb begin
    state_n = state;
    state_n = ap_ready ? RUN : (issue && last) ? DRAIN : ap_done ? IDLE : state;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
      addr <= '0;
      pass_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= issue;
      if (ap_ready) begin
        addr <= '0;
        pass_cnt <= '0;
      end else if (issue) begin
        addr <= addr == LAST_A ? '0 : addr + AW'(1);
        if (addr == LAST_A) pass_cnt <= pass_cnt + PW'(1);
      end
    end
  end
  weight_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk(ap_clk),
    .rst(ap_rst),
    .push(inflight),
    .pop(pop),
    .din(rom_q),
    .head(output_V_din),
    .count(count)
  );
endmodule
